// File: rtl/cpu_pkg.sv
// Shared definitions for the SimpleRISC-style control path.
// Holds the 5-bit opcode map, the aluSel unit codes, the sequencer state
// encoding and the one-hot ALU operation bundle used by the decoder and the
// control unit. Also provides a helper that says which opcodes write back
// into the register file.
package cpu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_MOD  = 5'b00100;
    localparam logic [4:0] OP_CMP  = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_OR   = 5'b00111;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [4:0] OP_MOV  = 5'b01001;
    localparam logic [4:0] OP_LSL  = 5'b01010;
    localparam logic [4:0] OP_LSR  = 5'b01011;
    localparam logic [4:0] OP_ASR  = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b01101;
    localparam logic [4:0] OP_LD   = 5'b01110;
    localparam logic [4:0] OP_ST   = 5'b01111;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BGT  = 5'b10001;
    localparam logic [4:0] OP_B    = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;
    localparam logic [4:0] OP_HLT  = 5'b11111;

    localparam logic [2:0] ALU_SEL_ADD   = 3'd0;
    localparam logic [2:0] ALU_SEL_MUL   = 3'd1;
    localparam logic [2:0] ALU_SEL_DIV   = 3'd2;
    localparam logic [2:0] ALU_SEL_SHIFT = 3'd3;
    localparam logic [2:0] ALU_SEL_LOGIC = 3'd4;
    localparam logic [2:0] ALU_SEL_MOV   = 3'd5;
    localparam logic [2:0] ALU_SEL_NONE  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_OPFETCH   = 3'd3,
        ST_EXECUTE   = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_e;

    typedef struct packed {
        logic is_add;
        logic is_sub;
        logic is_mul;
        logic is_div;
        logic is_mod;
        logic is_cmp;
        logic is_and;
        logic is_or;
        logic is_not;
        logic is_mov;
        logic is_lsl;
        logic is_lsr;
        logic is_asr;
    } alu_onehot_t;

    // Arithmetic/logic results (all except cmp), loads and the return
    // address of a call are the only things written to the register file.
    function automatic logic writes_register(input logic [4:0] op);
        logic wr;
        wr = 1'b0;
        if (op <= OP_ASR && op != OP_CMP) begin
            wr = 1'b1;
        end
        if (op == OP_LD || op == OP_CALL) begin
            wr = 1'b1;
        end
        return wr;
    endfunction

endpackage

// File: rtl/control_unit_alu_op_decoder.sv
// Combinational opcode-to-ALU decoder.
// Ports:
//   opcode  in  5  opcode of the decoded instruction
//   one_hot out 13 one-hot ALU operation (all zero for non-ALU opcodes)
//   alu_sel out 3  ALU unit select, ALU_SEL_NONE when no unit is used
// Loads and stores reuse the adder for address generation, so they decode
// as an add. Branches, nop, hlt and unassigned codes select no unit.
module alu_op_decoder
    import cpu_pkg::*;
(
    input  logic [4:0]  opcode,
    output alu_onehot_t one_hot,
    output logic [2:0]  alu_sel
);

    always_comb begin
        one_hot = '0;
        alu_sel = ALU_SEL_NONE;
        case (opcode)
            OP_ADD, OP_LD, OP_ST: begin
                one_hot.is_add = 1'b1;
                alu_sel        = ALU_SEL_ADD;
            end
            OP_SUB: begin
                one_hot.is_sub = 1'b1;
                alu_sel        = ALU_SEL_ADD;
            end
            OP_CMP: begin
                one_hot.is_cmp = 1'b1;
                alu_sel        = ALU_SEL_ADD;
            end
            OP_MUL: begin
                one_hot.is_mul = 1'b1;
                alu_sel        = ALU_SEL_MUL;
            end
            OP_DIV: begin
                one_hot.is_div = 1'b1;
                alu_sel        = ALU_SEL_DIV;
            end
            OP_MOD: begin
                one_hot.is_mod = 1'b1;
                alu_sel        = ALU_SEL_DIV;
            end
            OP_LSL: begin
                one_hot.is_lsl = 1'b1;
                alu_sel        = ALU_SEL_SHIFT;
            end
            OP_LSR: begin
                one_hot.is_lsr = 1'b1;
                alu_sel        = ALU_SEL_SHIFT;
            end
            OP_ASR: begin
                one_hot.is_asr = 1'b1;
                alu_sel        = ALU_SEL_SHIFT;
            end
            OP_AND: begin
                one_hot.is_and = 1'b1;
                alu_sel        = ALU_SEL_LOGIC;
            end
            OP_OR: begin
                one_hot.is_or = 1'b1;
                alu_sel       = ALU_SEL_LOGIC;
            end
            OP_NOT: begin
                one_hot.is_not = 1'b1;
                alu_sel        = ALU_SEL_LOGIC;
            end
            OP_MOV: begin
                one_hot.is_mov = 1'b1;
                alu_sel        = ALU_SEL_MOV;
            end
            default: begin
                one_hot = '0;
                alu_sel = ALU_SEL_NONE;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the SimpleRISC-style core.
// Steps every instruction through FETCH, DECODE, OPFETCH, EXECUTE and
// WRITEBACK, driving the datapath load/clear strobes, the one-hot ALU
// operation, the flag write and the branch-taken decision.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 leaves IDLE when high, ignored elsewhere
//   flagE, flagGt         registered compare flags
//   opcode                opcode of the decoded instruction
//   iOrReg, modifier      not used by this block
//   aluSel, isAdd..isAsr  ALU unit select and one-hot operation (EXECUTE only)
//   ld*/clr*/rst*/wr*     datapath register strobes
//   isSt, isRet           operand-fetch / next-PC selects
//   isBranchTaken         next-PC select, valid in WRITEBACK
// IDLE doubles as the reset state, so holding rst_n low keeps every
// datapath register cleared.
module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       flagE,
    input  logic       flagGt,
    input  logic [4:0] opcode,
    input  logic       iOrReg,
    input  logic [1:0] modifier,
    output logic [2:0] aluSel,
    output logic       isAdd,
    output logic       isSub,
    output logic       isMul,
    output logic       isDiv,
    output logic       isMod,
    output logic       isCmp,
    output logic       isAnd,
    output logic       isOr,
    output logic       isNot,
    output logic       isMov,
    output logic       isLsl,
    output logic       isLsr,
    output logic       isAsr,
    output logic       ldResult,
    output logic       clrResult,
    output logic       wrFlag,
    output logic       rstFlag,
    output logic       ldPC,
    output logic       clrPC,
    output logic       ldNPC,
    output logic       clrNPC,
    output logic       ldInst,
    output logic       clrInst,
    output logic       ldDecodeInst,
    output logic       clrDecodeInst,
    output logic       ldBrnchTarget,
    output logic       clrBrnchTarget,
    output logic       ldRegOutputData,
    output logic       clrOutputRegData,
    output logic       rstRegFile,
    output logic       wrRegister,
    output logic       isSt,
    output logic       isRet,
    output logic       isBranchTaken
);

    state_e      state_q;
    state_e      state_d;
    alu_onehot_t dec_one_hot;
    logic [2:0]  dec_alu_sel;
    alu_onehot_t exec_one_hot;
    logic        unused_inputs;

    // iOrReg and modifier are routed past this block to the ALU/decoder.
    assign unused_inputs = iOrReg ^ (^modifier);

    alu_op_decoder u_alu_op_decoder (
        .opcode  (opcode),
        .one_hot (dec_one_hot),
        .alu_sel (dec_alu_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        exec_one_hot     = '0;
        aluSel           = ALU_SEL_NONE;
        ldResult         = 1'b0;
        clrResult        = 1'b0;
        wrFlag           = 1'b0;
        rstFlag          = 1'b0;
        ldPC             = 1'b0;
        clrPC            = 1'b0;
        ldNPC            = 1'b0;
        clrNPC           = 1'b0;
        ldInst           = 1'b0;
        clrInst          = 1'b0;
        ldDecodeInst     = 1'b0;
        clrDecodeInst    = 1'b0;
        ldBrnchTarget    = 1'b0;
        clrBrnchTarget   = 1'b0;
        ldRegOutputData  = 1'b0;
        clrOutputRegData = 1'b0;
        rstRegFile       = 1'b0;
        wrRegister       = 1'b0;
        isSt             = 1'b0;
        isRet            = 1'b0;
        isBranchTaken    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clrPC            = 1'b1;
                clrNPC           = 1'b1;
                clrInst          = 1'b1;
                clrDecodeInst    = 1'b1;
                clrBrnchTarget   = 1'b1;
                clrResult        = 1'b1;
                clrOutputRegData = 1'b1;
                rstRegFile       = 1'b1;
                rstFlag          = 1'b1;
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ldInst  = 1'b1;
                ldNPC   = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ldDecodeInst  = 1'b1;
                ldBrnchTarget = 1'b1;
                state_d       = ST_OPFETCH;
            end
            ST_OPFETCH: begin
                ldRegOutputData = 1'b1;
                state_d         = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                exec_one_hot = dec_one_hot;
                aluSel       = dec_alu_sel;
                // Any opcode that uses an ALU unit captures a result.
                ldResult     = |dec_one_hot;
                wrFlag       = (opcode == OP_CMP);
                state_d      = (opcode == OP_HLT) ? ST_HALT : ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                ldPC          = 1'b1;
                wrRegister    = writes_register(opcode);
                isBranchTaken = (opcode == OP_B) || (opcode == OP_CALL) ||
                                (opcode == OP_RET) ||
                                ((opcode == OP_BEQ) && flagE) ||
                                ((opcode == OP_BGT) && flagGt);
                state_d       = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Operand-fetch and next-PC selects follow the opcode throughout an
        // instruction but stay quiet while idle or halted.
        if (state_q inside {ST_FETCH, ST_DECODE, ST_OPFETCH, ST_EXECUTE, ST_WRITEBACK}) begin
            isSt  = (opcode == OP_ST);
            isRet = (opcode == OP_RET);
        end
    end

    assign isAdd = exec_one_hot.is_add;
    assign isSub = exec_one_hot.is_sub;
    assign isMul = exec_one_hot.is_mul;
    assign isDiv = exec_one_hot.is_div;
    assign isMod = exec_one_hot.is_mod;
    assign isCmp = exec_one_hot.is_cmp;
    assign isAnd = exec_one_hot.is_and;
    assign isOr  = exec_one_hot.is_or;
    assign isNot = exec_one_hot.is_not;
    assign isMov = exec_one_hot.is_mov;
    assign isLsl = exec_one_hot.is_lsl;
    assign isLsr = exec_one_hot.is_lsr;
    assign isAsr = exec_one_hot.is_asr;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks instructions through the five
// phases and compares the full output bundle in every phase against
// hand-computed values, plus reset, halt and asynchronous reset behaviour.
module tb_control_unit;

    typedef struct packed {
        logic [2:0]  aluSel;
        logic [12:0] oneHot;
        logic ldResult;
        logic clrResult;
        logic wrFlag;
        logic rstFlag;
        logic ldPC;
        logic clrPC;
        logic ldNPC;
        logic clrNPC;
        logic ldInst;
        logic clrInst;
        logic ldDecodeInst;
        logic clrDecodeInst;
        logic ldBrnchTarget;
        logic clrBrnchTarget;
        logic ldRegOutputData;
        logic clrOutputRegData;
        logic rstRegFile;
        logic wrRegister;
        logic isSt;
        logic isRet;
        logic isBranchTaken;
    } out_t;

    // One-hot order, MSB first: add sub mul div mod cmp and or not mov lsl lsr asr
    localparam logic [12:0] OH_NONE = 13'h0000;
    localparam logic [12:0] OH_ADD  = 13'h1000;
    localparam logic [12:0] OH_MUL  = 13'h0400;
    localparam logic [12:0] OH_MOD  = 13'h0100;
    localparam logic [12:0] OH_CMP  = 13'h0080;
    localparam logic [12:0] OH_NOT  = 13'h0010;
    localparam logic [12:0] OH_MOV  = 13'h0008;
    localparam logic [12:0] OH_ASR  = 13'h0001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       flagE;
    logic       flagGt;
    logic [4:0] opcode;
    logic       iOrReg;
    logic [1:0] modifier;
    out_t       obs;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .flagE            (flagE),
        .flagGt           (flagGt),
        .opcode           (opcode),
        .iOrReg           (iOrReg),
        .modifier         (modifier),
        .aluSel           (obs.aluSel),
        .isAdd            (obs.oneHot[12]),
        .isSub            (obs.oneHot[11]),
        .isMul            (obs.oneHot[10]),
        .isDiv            (obs.oneHot[9]),
        .isMod            (obs.oneHot[8]),
        .isCmp            (obs.oneHot[7]),
        .isAnd            (obs.oneHot[6]),
        .isOr             (obs.oneHot[5]),
        .isNot            (obs.oneHot[4]),
        .isMov            (obs.oneHot[3]),
        .isLsl            (obs.oneHot[2]),
        .isLsr            (obs.oneHot[1]),
        .isAsr            (obs.oneHot[0]),
        .ldResult         (obs.ldResult),
        .clrResult        (obs.clrResult),
        .wrFlag           (obs.wrFlag),
        .rstFlag          (obs.rstFlag),
        .ldPC             (obs.ldPC),
        .clrPC            (obs.clrPC),
        .ldNPC            (obs.ldNPC),
        .clrNPC           (obs.clrNPC),
        .ldInst           (obs.ldInst),
        .clrInst          (obs.clrInst),
        .ldDecodeInst     (obs.ldDecodeInst),
        .clrDecodeInst    (obs.clrDecodeInst),
        .ldBrnchTarget    (obs.ldBrnchTarget),
        .clrBrnchTarget   (obs.clrBrnchTarget),
        .ldRegOutputData  (obs.ldRegOutputData),
        .clrOutputRegData (obs.clrOutputRegData),
        .rstRegFile       (obs.rstRegFile),
        .wrRegister       (obs.wrRegister),
        .isSt             (obs.isSt),
        .isRet            (obs.isRet),
        .isBranchTaken    (obs.isBranchTaken)
    );

    function automatic out_t idleExp();
        out_t e;
        e                  = '0;
        e.aluSel           = 3'd7;
        e.clrPC            = 1'b1;
        e.clrNPC           = 1'b1;
        e.clrInst          = 1'b1;
        e.clrDecodeInst    = 1'b1;
        e.clrBrnchTarget   = 1'b1;
        e.clrResult        = 1'b1;
        e.clrOutputRegData = 1'b1;
        e.rstRegFile       = 1'b1;
        e.rstFlag          = 1'b1;
        return e;
    endfunction

    function automatic out_t haltExp();
        out_t e;
        e        = '0;
        e.aluSel = 3'd7;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input out_t expected);
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] op, input logic fe, input logic fgt);
        opcode = op;
        flagE  = fe;
        flagGt = fgt;
    endtask

    // Runs one instruction from a point where the next rising edge enters
    // FETCH, checking each phase at the following falling edge.
    task automatic runInstr(input string name, input logic [4:0] op,
                            input logic fe, input logic fgt,
                            input logic [12:0] expOh, input logic [2:0] expSel,
                            input logic expLdRes, input logic expWrFlag,
                            input logic expWrReg, input logic expTaken,
                            input logic expSt, input logic expRet,
                            input logic isHalt);
        out_t e;
        applyStimulus(op, fe, fgt);

        @(negedge clk);
        e = haltExp(); e.isSt = expSt; e.isRet = expRet;
        e.ldInst = 1'b1; e.ldNPC = 1'b1;
        checkOutput({name, ".fetch"}, e);

        @(negedge clk);
        e = haltExp(); e.isSt = expSt; e.isRet = expRet;
        e.ldDecodeInst = 1'b1; e.ldBrnchTarget = 1'b1;
        checkOutput({name, ".decode"}, e);

        @(negedge clk);
        e = haltExp(); e.isSt = expSt; e.isRet = expRet;
        e.ldRegOutputData = 1'b1;
        checkOutput({name, ".opfetch"}, e);

        @(negedge clk);
        e = haltExp(); e.isSt = expSt; e.isRet = expRet;
        e.oneHot = expOh; e.aluSel = expSel;
        e.ldResult = expLdRes; e.wrFlag = expWrFlag;
        checkOutput({name, ".execute"}, e);

        @(negedge clk);
        if (isHalt) begin
            checkOutput({name, ".halt"}, haltExp());
        end else begin
            e = haltExp(); e.isSt = expSt; e.isRet = expRet;
            e.ldPC = 1'b1; e.wrRegister = expWrReg; e.isBranchTaken = expTaken;
            checkOutput({name, ".writeback"}, e);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        flagE    = 1'b0;
        flagGt   = 1'b0;
        opcode   = 5'b00000;
        iOrReg   = 1'b0;
        modifier = 2'b00;
        #1;
        checkOutput("reset_at_t0", idleExp());

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("idle_wait%0d", i), idleExp());
        end

        start = 1'b1;
        //       name     op        fe    fgt   oneHot   sel   ldR   wrF   wrR   tkn   st    ret   hlt
        runInstr("add",   5'b00000, 1'b0, 1'b0, OH_ADD,  3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        start    = 1'b0;
        iOrReg   = 1'b1;
        modifier = 2'b11;
        runInstr("cmp",   5'b00101, 1'b0, 1'b0, OH_CMP,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runInstr("beq_t", 5'b10000, 1'b1, 1'b0, OH_NONE, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        runInstr("beq_n", 5'b10000, 1'b0, 1'b1, OH_NONE, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runInstr("bgt_t", 5'b10001, 1'b0, 1'b1, OH_NONE, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        runInstr("bgt_n", 5'b10001, 1'b1, 1'b0, OH_NONE, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runInstr("ret",   5'b10100, 1'b0, 1'b0, OH_NONE, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        runInstr("st",    5'b01111, 1'b0, 1'b0, OH_ADD,  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        runInstr("ld",    5'b01110, 1'b0, 1'b0, OH_ADD,  3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runInstr("mul",   5'b00010, 1'b0, 1'b0, OH_MUL,  3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runInstr("mod",   5'b00100, 1'b0, 1'b0, OH_MOD,  3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runInstr("asr",   5'b01100, 1'b0, 1'b0, OH_ASR,  3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runInstr("not",   5'b01000, 1'b0, 1'b0, OH_NOT,  3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runInstr("mov",   5'b01001, 1'b0, 1'b0, OH_MOV,  3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runInstr("call",  5'b10011, 1'b0, 1'b0, OH_NONE, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        runInstr("b",     5'b10010, 1'b0, 1'b0, OH_NONE, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        runInstr("nop",   5'b01101, 1'b1, 1'b1, OH_NONE, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runInstr("undef", 5'b10101, 1'b1, 1'b1, OH_NONE, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runInstr("hlt",   5'b11111, 1'b0, 1'b0, OH_NONE, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Halt must hold regardless of start or opcode changes.
        start  = 1'b1;
        opcode = 5'b00000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput($sformatf("halt_hold%0d", i), haltExp());
        end

        // Reset out of HALT, then abort an add in EXECUTE with rst_n.
        rst_n = 1'b0;
        #1;
        checkOutput("halt_reset", idleExp());
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(5'b00000, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        begin
            out_t e;
            e = haltExp();
            e.oneHot = OH_ADD; e.aluSel = 3'd0; e.ldResult = 1'b1;
            checkOutput("pre_abort_execute", e);
        end
        start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_abort", idleExp());
        @(negedge clk);
        checkOutput("abort_held", idleExp());
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_idle", idleExp());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
